// File: rtl/adc_serial_responder.sv
// Slave-side stand-in for an 8-channel 12-bit serial ADC (ADC128S022 framing) with per-channel test patterns.
// Optional build macro ADC_RESP_NOISE_EN adds LFSR noise on sample bits [2:0] (all channels except ch3).
module adc_serial_responder #(
  parameter int          RAMP_STEP          = 16,
  parameter int          SQUARE_HALF_FRAMES = 256,
  parameter logic [11:0] CONST_VALUE        = 12'h800,
  parameter int          SYNC_STAGES        = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       ADC_SCLK,
  input  logic       ADC_CS_N,
  input  logic       ADC_SADDR,
  input  logic [1:0] PAT_SEL,
  output logic       ADC_SDAT,
  output logic       FRAME_DONE,
  output logic [2:0] LAST_CH
);

  localparam logic [12:0] STEP13 = 13'(RAMP_STEP);
  localparam int SQ_W = (SQUARE_HALF_FRAMES > 1) ? $clog2(SQUARE_HALF_FRAMES) : 1;
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQUARE_HALF_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, TAIL} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_n_sync_reg, saddr_sync_reg;
  logic sclk_prev_reg, cs_n_prev_reg;
  logic sclk_s, cs_n_s, saddr_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [15:0]     shift_reg;
  logic [3:0]      bit_cnt_reg;
  logic [2:0]      addr_reg, next_ch_reg, last_ch_reg;
  logic [11:0]     ramp_reg, triangle_reg;
  logic            tri_up_reg, sq_high_reg;
  logic [SQ_W-1:0] sq_cnt_reg;
  logic [12:0]     tri_sum;
  logic [11:0]     square_val, ch0_val, base_val, sample_val;
`ifdef ADC_RESP_NOISE_EN
  logic [15:0]     lfsr_reg;
`endif

  // Pure synchronizers; the edge detector reloads from them every cycle, so a reset
  // taken while CS_N is held low never manufactures a false falling edge.
  always_ff @(posedge CLOCK) begin
    sclk_sync_reg  <= {sclk_sync_reg[SYNC_STAGES-2:0], ADC_SCLK};
    cs_n_sync_reg  <= {cs_n_sync_reg[SYNC_STAGES-2:0], ADC_CS_N};
    saddr_sync_reg <= {saddr_sync_reg[SYNC_STAGES-2:0], ADC_SADDR};
    sclk_prev_reg  <= sclk_s;
    cs_n_prev_reg  <= cs_n_s;
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_reg[SYNC_STAGES-1];
  assign saddr_s   = saddr_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign cs_fall   = ~cs_n_s & cs_n_prev_reg;
  assign cs_rise   = cs_n_s & ~cs_n_prev_reg;

  always_comb begin
    state_next = state_reg;
    ADC_SDAT   = 1'b0;
    FRAME_DONE = 1'b0;
    case (state_reg)
      IDLE:  if (cs_fall) state_next = LOAD;
      LOAD:  state_next = cs_rise ? IDLE : SHIFT;
      SHIFT: begin
        ADC_SDAT = shift_reg[15];
        if (cs_rise) state_next = IDLE;
        else if (sclk_rise && bit_cnt_reg == 4'd15) state_next = DONE;
      end
      DONE: begin
        FRAME_DONE = 1'b1;
        state_next = cs_rise ? IDLE : TAIL;
      end
      TAIL:    if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample selection for the channel latched by the previous frame
  always_comb begin
    square_val = sq_high_reg ? 12'hC00 : 12'h400;
    case (PAT_SEL)
      2'd0:    ch0_val = ramp_reg;
      2'd1:    ch0_val = triangle_reg;
      2'd2:    ch0_val = square_val;
      default: ch0_val = CONST_VALUE;
    endcase
    case (next_ch_reg)
      3'd0:    base_val = ch0_val;
      3'd1:    base_val = triangle_reg;
      3'd2:    base_val = square_val;
      3'd3:    base_val = CONST_VALUE;
      default: base_val = {next_ch_reg, 9'h000};
    endcase
`ifdef ADC_RESP_NOISE_EN
    sample_val = base_val ^ {9'h000, (next_ch_reg == 3'd3) ? 3'b000 : lfsr_reg[2:0]};
`else
    sample_val = base_val;
`endif
  end

  assign tri_sum = {1'b0, triangle_reg} + STEP13;
  assign LAST_CH = last_ch_reg;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      addr_reg     <= '0;
      next_ch_reg  <= '0;
      last_ch_reg  <= '0;
      ramp_reg     <= '0;
      triangle_reg <= '0;
      tri_up_reg   <= 1'b1;
      sq_high_reg  <= 1'b0;
      sq_cnt_reg   <= '0;
`ifdef ADC_RESP_NOISE_EN
      lfsr_reg     <= 16'hACE1;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        LOAD: begin
          shift_reg   <= {4'b0000, sample_val};
          bit_cnt_reg <= '0;
          addr_reg    <= '0;
        end
        SHIFT: if (!cs_rise) begin
          if (sclk_fall) shift_reg <= {shift_reg[14:0], 1'b0};
          if (sclk_rise) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            // Rises 3, 4, 5 carry the channel address MSB first
            case (bit_cnt_reg)
              4'd2:    addr_reg[2] <= saddr_s;
              4'd3:    addr_reg[1] <= saddr_s;
              4'd4:    addr_reg[0] <= saddr_s;
              default: ;
            endcase
          end
        end
        DONE: begin
          next_ch_reg <= addr_reg;
          last_ch_reg <= addr_reg;
          ramp_reg    <= ramp_reg + STEP13[11:0];
          if (tri_up_reg) begin
            if (tri_sum > 13'd4095) begin
              triangle_reg <= 12'hFFF;
              tri_up_reg   <= 1'b0;
            end else begin
              triangle_reg <= tri_sum[11:0];
            end
          end else if ({1'b0, triangle_reg} < STEP13) begin
            triangle_reg <= '0;
            tri_up_reg   <= 1'b1;
          end else begin
            triangle_reg <= triangle_reg - STEP13[11:0];
          end
          if (sq_cnt_reg == SQ_LAST) begin
            sq_cnt_reg  <= '0;
            sq_high_reg <= ~sq_high_reg;
          end else begin
            sq_cnt_reg <= sq_cnt_reg + 1'b1;
          end
`ifdef ADC_RESP_NOISE_EN
          lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
